regfile_read_stage: RTL and testbench

Register-file storage plus registered dual read port. Supplies the two operands (reg0, reg1) that the downstream compare/logic function stage (eq/and/or/not) consumes. One write port, one read request per cycle, 1-cycle read latency, valid/ready output handshake with stall hold. Write-to-read bypass so the compare stage always sees the newest value.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_if.sv | 36 +++
 rtl/regfile_storage_array.sv | 39 +++
 rtl/regfile_read_stage.sv | 87 ++++++++
 tb/tb_regfile_read_stage.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizing for the register-file read stage.
// Included first; every other file imports it.
package regfile_pkg;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = 8;

  typedef logic [WIDTH-1:0]  word_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/regfile_if.sv
// Write port, read request and operand handshake bundle.
// master drives requests/writes, slave is the read stage.
interface regfile_if;
  import regfile_pkg::*;

  logic  wr_en;
  addr_t wr_addr;
  word_t wr_data;
  logic  req_valid;
  logic  req_ready;
  addr_t rd_addr0;
  addr_t rd_addr1;
  logic  out_valid;
  logic  out_ready;
  word_t reg0;
  word_t reg1;
  logic  same_addr;
  cnt_t  xfer_cnt;

  modport master (
    output wr_en, wr_addr, wr_data,
    output req_valid, rd_addr0, rd_addr1,
    output out_ready,
    input  req_ready, out_valid,
    input  reg0, reg1, same_addr, xfer_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  req_valid, rd_addr0, rd_addr1,
    input  out_ready,
    output req_ready, out_valid,
    output reg0, reg1, same_addr, xfer_cnt
  );

endinterface

// File: rtl/regfile_storage_array.sv
// DEPTH x WIDTH register storage, one write port and
// two combinational read ports with write bypass.
module regfile_storage_array
  import regfile_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en,
  input  addr_t wr_addr,
  input  word_t wr_data,
  input  addr_t rd_addr0,
  input  addr_t rd_addr1,
  output word_t rd_data0,
  output word_t rd_data1
);

  word_t mem_q [DEPTH];
  word_t mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Reading the next-state array gives write-to-read bypass for free.
  assign rd_data0 = mem_d[rd_addr0];
  assign rd_data1 = mem_d[rd_addr1];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/regfile_read_stage.sv
// Register-file read stage: storage, registered operand pair,
// valid/ready output handshake and saturating transfer counter.
module regfile_read_stage
  import regfile_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  regfile_if.slave   bus
);

  state_e state_q, state_d;
  word_t  reg0_q, reg0_d;
  word_t  reg1_q, reg1_d;
  logic   same_q, same_d;
  cnt_t   cnt_q, cnt_d;

  word_t  rd_data0;
  word_t  rd_data1;
  logic   req_ready;
  logic   accept;
  logic   xfer;

  regfile_storage_array u_storage (
    .clk      (CLK),
    .rst      (RESET),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .rd_addr0 (bus.rd_addr0),
    .rd_addr1 (bus.rd_addr1),
    .rd_data0 (rd_data0),
    .rd_data1 (rd_data1)
  );

  assign req_ready = (state_q == EMPTY) || bus.out_ready;
  assign accept    = bus.req_valid && req_ready;
  assign xfer      = (state_q == FULL) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    reg0_d  = reg0_q;
    reg1_d  = reg1_q;
    same_d  = same_q;
    cnt_d   = cnt_q;
    if (xfer && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Arms are exclusive: a transfer without a request cannot accept.
    unique case (1'b1)
      accept: begin
        state_d = FULL;
        reg0_d  = rd_data0;
        reg1_d  = rd_data1;
        same_d  = (bus.rd_addr0 == bus.rd_addr1);
      end
      (xfer && !bus.req_valid): begin
        state_d = EMPTY;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= EMPTY;
      reg0_q  <= '0;
      reg1_q  <= '0;
      same_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      reg0_q  <= reg0_d;
      reg1_q  <= reg1_d;
      same_q  <= same_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.reg0      = reg0_q;
  assign bus.reg1      = reg1_q;
  assign bus.same_addr = same_q;
  assign bus.xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_regfile_read_stage.sv
// Directed + random bench for regfile_read_stage against a
// behavioural register-file / output-slot model.
module tb_regfile_read_stage;
  import regfile_pkg::*;

  logic CLK = 1'b0;
  logic RESET;

  regfile_if bus ();

  regfile_read_stage dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;
  string phase = "init";

  int  m_mem [DEPTH];
  bit  m_valid = 1'b0;
  int  m_r0 = 0;
  int  m_r1 = 0;
  bit  m_same = 1'b0;
  int  m_cnt = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h",
             phase, tag, obs, exp);
    end
  endtask

  task automatic step(bit rst, bit we, int wa, int wd,
                      bit rv, int a0, int a1, bit ordy);
    bit rdy;
    RESET         = rst;
    bus.wr_en     = we;
    bus.wr_addr   = addr_t'(wa);
    bus.wr_data   = word_t'(wd);
    bus.req_valid = rv;
    bus.rd_addr0  = addr_t'(a0);
    bus.rd_addr1  = addr_t'(a1);
    bus.out_ready = ordy;
    #1;
    rdy = !m_valid || ordy;
    if (!rst) chk("req_ready", 32'(bus.req_ready), 32'(rdy));
    @(posedge CLK);
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = 0;
      m_valid = 0;
      m_r0 = 0;
      m_r1 = 0;
      m_same = 0;
      m_cnt = 0;
    end else begin
      if (m_valid && ordy && m_cnt < 255) m_cnt++;
      if (rv && rdy) begin
        m_r0 = (we && wa == a0) ? wd : m_mem[a0];
        m_r1 = (we && wa == a1) ? wd : m_mem[a1];
        m_same = (a0 == a1);
        m_valid = 1;
      end else if (m_valid && ordy) begin
        m_valid = 0;
      end
      if (we) m_mem[wa] = wd;
    end
    @(negedge CLK);
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("reg0", 32'(bus.reg0), 32'(m_r0));
    chk("reg1", 32'(bus.reg1), 32'(m_r1));
    chk("same_addr", 32'(bus.same_addr), 32'(m_same));
    chk("xfer_cnt", 32'(bus.xfer_cnt), 32'(m_cnt));
  endtask

  task automatic idle(bit ordy);
    step(0, 0, 0, 0, 0, 0, 0, ordy);
  endtask

  task automatic rnd_step(int rv_pct, int rdy_pct);
    step(0, 1'($urandom_range(1)),
         int'($urandom_range(DEPTH - 1)),
         int'($urandom_range(16'hFFFF)),
         ($urandom_range(99) < rv_pct),
         int'($urandom_range(DEPTH - 1)),
         int'($urandom_range(DEPTH - 1)),
         ($urandom_range(99) < rdy_pct));
  endtask

  initial begin
    int base;
    int k;

    phase = "reset";
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    idle(1);

    phase = "basic";
    step(0, 1, 1, 16'h00AA, 0, 0, 0, 1);
    step(0, 1, 2, 16'h00AA, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1, 2, 1);
    chk("basic_reg0", 32'(bus.reg0), 32'h00AA);
    chk("basic_same", 32'(bus.same_addr), 32'h0);
    idle(1);
    chk("basic_cnt", 32'(bus.xfer_cnt), 32'd1);

    phase = "bypass";
    step(0, 1, 3, 16'h1111, 0, 0, 0, 1);
    step(0, 1, 3, 16'h2222, 1, 3, 3, 1);
    chk("byp_reg0", 32'(bus.reg0), 32'h2222);
    chk("byp_reg1", 32'(bus.reg1), 32'h2222);
    chk("byp_same", 32'(bus.same_addr), 32'h1);
    idle(1);

    phase = "stall";
    step(0, 1, 0, 16'h0005, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 16'h0009, 1, 0, 0, 0);
    idle(0);
    step(0, 0, 0, 0, 1, 1, 1, 0);
    chk("snap_reg0", 32'(bus.reg0), 32'h0005);
    chk("stall_rdy", 32'(bus.req_ready), 32'h0);
    step(0, 0, 0, 0, 1, 0, 0, 1);
    chk("post_reg0", 32'(bus.reg0), 32'h0009);
    idle(1);

    phase = "b2b";
    base = m_cnt;
    for (int i = 0; i < 10; i++) begin
      rnd_step(100, 100);
      chk("b2b_valid", 32'(bus.out_valid), 32'h1);
    end
    idle(1);
    chk("b2b_cnt", 32'(bus.xfer_cnt), 32'(base + 10));

    phase = "random";
    k = 0;
    while (m_cnt < 255 && k < 2000) begin
      rnd_step(75, 75);
      k++;
    end
    chk("sat_budget", 32'(k < 2000), 32'h1);
    for (int i = 0; i < 40; i++) rnd_step(90, 90);
    chk("sat_cnt", 32'(bus.xfer_cnt), 32'd255);

    phase = "midreset";
    step(0, 1, 2, 16'hBEEF, 1, 2, 1, 1);
    step(0, 0, 0, 0, 1, 3, 0, 0);
    step(1, 1, 1, 16'h7777, 1, 1, 1, 0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_cnt", 32'(bus.xfer_cnt), 32'h0);
    step(0, 0, 0, 0, 1, 0, 1, 1);
    chk("rst_mem0", 32'(bus.reg0), 32'h0);
    chk("rst_mem1", 32'(bus.reg1), 32'h0);
    step(0, 0, 0, 0, 1, 2, 3, 1);
    chk("rst_mem2", 32'(bus.reg0), 32'h0);
    chk("rst_mem3", 32'(bus.reg1), 32'h0);
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
